// File: rtl/parity_arbiter.sv
// parity_arbiter: round-robin shared even/odd classifier for two requesters,
// with per-requester saturating even/odd event counters.
module parity_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [1:0]       req,
    input  logic [3:0]       data0,
    input  logic [3:0]       data1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             done_even,
    output logic [CNT_W-1:0] even_cnt0,
    output logic [CNT_W-1:0] odd_cnt0,
    output logic [CNT_W-1:0] even_cnt1,
    output logic [CNT_W-1:0] odd_cnt1
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        EVAL,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic             winner;
    logic             win_nxt;
    logic [3:0]       val;
    logic             even_r;
    logic             id_r;
    logic [3:0]       inc;
    logic [CNT_W-1:0] cnt [4];

    always_comb begin
        state_nxt = state;
        win_nxt   = winner;
        unique case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = GRANT;
                    unique case (req)
                        2'b01:   win_nxt = 1'b0;
                        2'b10:   win_nxt = 1'b1;
                        default: win_nxt = prio;
                    endcase
                end
            end
            GRANT:   state_nxt = EVAL;
            EVAL:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            winner <= 1'b0;
            prio   <= 1'b0;
            val    <= 4'h0;
            even_r <= 1'b0;
            id_r   <= 1'b0;
        end else begin
            state  <= state_nxt;
            winner <= win_nxt;
            if (state == GRANT) begin
                val <= winner ? data1 : data0;
            end
            if (state == EVAL) begin
                even_r <= ~val[0];
                id_r   <= winner;
            end
            if (state == RESP) begin
                prio <= ~winner;
            end
        end
    end

    assign gnt       = (state == GRANT) ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state != IDLE);
    assign done      = (state == RESP);
    assign done_id   = id_r;
    assign done_even = even_r;

    // counter order: even0, odd0, even1, odd1
    always_comb begin
        inc = 4'b0000;
        if (state == RESP) begin
            inc[{winner, ~even_r}] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (clear) begin
                    cnt[i] <= '0;
                end else if (inc[i] && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign even_cnt0 = cnt[0];
    assign odd_cnt0  = cnt[1];
    assign even_cnt1 = cnt[2];
    assign odd_cnt1  = cnt[3];

endmodule

// File: tb/tb_parity_arbiter.sv
// tb_parity_arbiter: table-driven and scoreboard checks of parity_arbiter,
// with a narrow-counter instance for saturation.
module tb_parity_arbiter;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] req   = 2'b00;
    logic [3:0] data0 = 4'h0;
    logic [3:0] data1 = 4'h0;

    logic [1:0] gnt, gnt_s;
    logic       busy, busy_s, done, done_s;
    logic       done_id, done_id_s, done_even, done_even_s;
    logic [7:0] ec0, oc0, ec1, oc1;
    logic [1:0] ec0_s, oc0_s, ec1_s, oc1_s;

    parity_arbiter #(.CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .clear(clear), .req(req),
        .data0(data0), .data1(data1), .gnt(gnt), .busy(busy),
        .done(done), .done_id(done_id), .done_even(done_even),
        .even_cnt0(ec0), .odd_cnt0(oc0),
        .even_cnt1(ec1), .odd_cnt1(oc1)
    );

    parity_arbiter #(.CNT_W(2)) u_small (
        .clk(clk), .reset(reset), .clear(clear), .req(req),
        .data0(data0), .data1(data1), .gnt(gnt_s), .busy(busy_s),
        .done(done_s), .done_id(done_id_s), .done_even(done_even_s),
        .even_cnt0(ec0_s), .odd_cnt0(oc0_s),
        .even_cnt1(ec1_s), .odd_cnt1(oc1_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [1:0] gnt;
        logic       id;
        logic       even;
    } vec_t;

    typedef struct {
        logic id;
        logic even;
    } exp_t;

    exp_t       sbq [$];
    vec_t       tbl [8];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] m8 [4];
    logic [1:0] m2 [4];
    exp_t       mon_e;
    bit         mon_hit;
    int         mon_k;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic check_cnts();
        chk("even_cnt0", ec0, m8[0]);
        chk("odd_cnt0", oc0, m8[1]);
        chk("even_cnt1", ec1, m8[2]);
        chk("odd_cnt1", oc1, m8[3]);
        chk("even_cnt0_s", ec0_s, m2[0]);
        chk("odd_cnt0_s", oc0_s, m2[1]);
        chk("even_cnt1_s", ec1_s, m2[2]);
        chk("odd_cnt1_s", oc1_s, m2[3]);
    endtask

    // scoreboard: pops on every result strobe, tracks the counter model
    always @(negedge clk) begin
        mon_hit = 1'b0;
        if (!reset) begin
            sbq.delete();
            for (int i = 0; i < 4; i++) begin
                m8[i] = '0;
                m2[i] = '0;
            end
        end else begin
            if (done) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1, expected none at %0t",
                             $time);
                end else begin
                    mon_e   = sbq.pop_front();
                    mon_hit = 1'b1;
                    chk("done_id", done_id, mon_e.id);
                    chk("done_even", done_even, mon_e.even);
                    chk("done_s", done_s, 1);
                    chk("done_even_s", done_even_s, mon_e.even);
                end
            end
            if (clear) begin
                for (int i = 0; i < 4; i++) begin
                    m8[i] = '0;
                    m2[i] = '0;
                end
            end else if (mon_hit) begin
                mon_k = {30'd0, mon_e.id, ~mon_e.even};
                if (m8[mon_k] != 8'hFF) m8[mon_k] = m8[mon_k] + 8'd1;
                if (m2[mon_k] != 2'd3) m2[mon_k] = m2[mon_k] + 2'd1;
            end
        end
    end

    task automatic txn(input vec_t v, input bit clr_resp);
        exp_t e;
        @(posedge clk); #1;
        req   = v.req;
        data0 = v.d0;
        data1 = v.d1;
        e.id   = v.id;
        e.even = v.even;
        sbq.push_back(e);
        @(negedge clk);
        chk("gnt_idle", gnt, 0);
        @(negedge clk);
        chk("gnt", gnt, v.gnt);
        chk("gnt_s", gnt_s, v.gnt);
        chk("busy", busy, 1);
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk);
        chk("done_early", done, 0);
        @(posedge clk); #1;
        clear = clr_resp;
        @(negedge clk);
        chk("done", done, 1);
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("busy_end", busy, 0);
        chk("done_end", done, 0);
        check_cnts();
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check_cnts();
    endtask

    initial begin
        tbl[0] = '{2'b01, 4'h6, 4'h0, 2'b01, 1'b0, 1'b1};
        tbl[1] = '{2'b10, 4'h0, 4'h5, 2'b10, 1'b1, 1'b0};
        tbl[2] = '{2'b11, 4'h9, 4'h2, 2'b01, 1'b0, 1'b0};
        tbl[3] = '{2'b11, 4'h4, 4'h7, 2'b10, 1'b1, 1'b0};
        tbl[4] = '{2'b10, 4'h0, 4'hC, 2'b10, 1'b1, 1'b1};
        tbl[5] = '{2'b11, 4'hF, 4'h0, 2'b01, 1'b0, 1'b0};
        tbl[6] = '{2'b01, 4'hA, 4'h3, 2'b01, 1'b0, 1'b1};
        tbl[7] = '{2'b11, 4'h1, 4'hE, 2'b10, 1'b1, 1'b1};

        // reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            req   = 2'($urandom_range(3));
            data0 = 4'($urandom_range(15));
            data1 = 4'($urandom_range(15));
            @(negedge clk);
            chk("rst_gnt", gnt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_done_id", done_id, 0);
            chk("rst_done_even", done_even, 0);
        end
        check_cnts();
        @(posedge clk); #1;
        req   = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            txn(tbl[i], 1'b0);
        end

        // contention: both held, grants alternate from prio=0
        pulse_clear();
        @(posedge clk); #1;
        req   = 2'b11;
        data0 = 4'h3;
        data1 = 4'h8;
        for (int i = 0; i < 4; i++) begin
            sbq.push_back('{logic'(i % 2), logic'(i % 2)});
        end
        @(negedge clk);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c % 4 == 1) begin
                chk("cont_gnt", gnt, ((c / 4) % 2 == 1) ? 2'b10 : 2'b01);
            end else begin
                chk("cont_gnt_off", gnt, 0);
            end
        end
        @(posedge clk); #1;
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("cont_odd0", oc0, 2);
        chk("cont_even1", ec1, 2);
        chk("cont_busy", busy, 0);
        check_cnts();

        // saturation on the 2-bit instance
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            logic [1:0] sat_exp;
            sat_exp = (i < 3) ? 2'(i + 1) : 2'd3;
            txn('{2'b10, 4'h0, 4'(2 * i + 1), 2'b10, 1'b1, 1'b0}, 1'b0);
            chk("sat_odd1", oc1_s, sat_exp);
            chk("wide_odd1", oc1, i + 1);
        end

        // clear in the same cycle as an increment
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            txn('{2'b01, 4'(2 * i), 4'h0, 2'b01, 1'b0, 1'b1}, 1'b0);
        end
        chk("pre_clr_even0", ec0, 5);
        txn('{2'b01, 4'h8, 4'h0, 2'b01, 1'b0, 1'b1}, 1'b1);
        chk("clr_win_even0", ec0, 0);

        // reset during EVAL with prio=1 pending
        @(posedge clk); #1;
        req   = 2'b01;
        data0 = 4'h6;
        @(negedge clk);
        @(negedge clk);
        chk("mid_gnt", gnt, 2'b01);
        @(posedge clk); #1;
        req = 2'b00;
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_busy2", busy, 0);
        check_cnts();
        txn('{2'b11, 4'h2, 4'h3, 2'b01, 1'b0, 1'b1}, 1'b0);

        repeat (2) @(negedge clk);
        chk("sbq_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
